// File: rtl/vga_pkg.sv
// SVGA 800x600@60 timing constants and shared types
// for the sprite generator slice.
package vga_pkg;

  localparam int H_ACTIVE = 800;
  localparam int H_FP     = 40;
  localparam int H_SYNC   = 128;
  localparam int H_BP     = 88;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 600;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 4;
  localparam int V_BP     = 23;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int CNT_W = 11;
  localparam int CMP_W = 13;

  typedef logic [CNT_W-1:0]        cnt_t;
  typedef logic signed [CMP_W-1:0] scmp_t;
  typedef logic signed [10:0]      pos_t;
  typedef logic [23:0]             rgb_t;

  localparam pos_t RESET_CX = 11'sd400;
  localparam pos_t RESET_CY = 11'sd300;

  function automatic logic in_win(
    input cnt_t c,
    input int   lo,
    input int   hi
  );
    return (int'(c) >= lo) && (int'(c) <= hi);
  endfunction

endpackage

// File: rtl/vga_sprite_gen_if.sv
// Video pin bundle between the sprite generator
// and the display DAC / sync drivers.
interface vga_sprite_gen_if;

  logic       hsync;
  logic       vsync;
  logic       blank;
  logic [7:0] r;
  logic [7:0] g;
  logic [7:0] b;

  modport master (
    output hsync, vsync, blank,
    output r, g, b
  );

  modport slave (
    input hsync, vsync, blank,
    input r, g, b
  );

endinterface

// File: rtl/vga_timing.sv
// Raster counters plus registered sync, blank
// and frame pulses, one cycle behind the counters.
import vga_pkg::*;

module vga_timing #(
  parameter int H_ACT   = H_ACTIVE,
  parameter int H_FRONT = H_FP,
  parameter int H_SYN   = H_SYNC,
  parameter int H_BACK  = H_BP,
  parameter int V_ACT   = V_ACTIVE,
  parameter int V_FRONT = V_FP,
  parameter int V_SYN   = V_SYNC,
  parameter int V_BACK  = V_BP
) (
  input  logic clk,
  input  logic reset_n,
  output cnt_t hcnt_o,
  output cnt_t vcnt_o,
  output logic last_o,
  output logic hsync_o,
  output logic vsync_o,
  output logic blank_o,
  output logic sof_o,
  output logic eof_o
);

  localparam int HT  = H_ACT + H_FRONT + H_SYN + H_BACK;
  localparam int VT  = V_ACT + V_FRONT + V_SYN + V_BACK;
  localparam int HS0 = H_ACT + H_FRONT;
  localparam int VS0 = V_ACT + V_FRONT;

  cnt_t hcnt_q, hcnt_d;
  cnt_t vcnt_q, vcnt_d;
  logic hend, vend;
  logic hsync_q, vsync_q, blank_q;
  logic sof_q, eof_q;

  always_comb begin
    hend   = hcnt_q == cnt_t'(HT - 1);
    vend   = vcnt_q == cnt_t'(VT - 1);
    hcnt_d = hend ? '0 : hcnt_q + 1'b1;
    vcnt_d = vcnt_q;
    if (hend) begin
      vcnt_d = vend ? '0 : vcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
      blank_q <= 1'b1;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
    end else begin
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      hsync_q <= in_win(hcnt_q, HS0, HS0 + H_SYN - 1);
      vsync_q <= in_win(vcnt_q, VS0, VS0 + V_SYN - 1);
      blank_q <= !(in_win(hcnt_q, 0, H_ACT - 1) &&
                   in_win(vcnt_q, 0, V_ACT - 1));
      eof_q   <= (hcnt_q == cnt_t'(H_ACT - 1)) &&
                 (vcnt_q == cnt_t'(V_ACT - 1));
      sof_q   <= (hcnt_q == cnt_t'(HT - 2)) && vend;
    end
  end

  assign hcnt_o  = hcnt_q;
  assign vcnt_o  = vcnt_q;
  assign last_o  = hend && vend;
  assign hsync_o = hsync_q;
  assign vsync_o = vsync_q;
  assign blank_o = blank_q;
  assign sof_o   = sof_q;
  assign eof_o   = eof_q;

endmodule

// File: rtl/vga_sprite_gen.sv
// SVGA timing + single filled-square sprite; the centre is latched per frame.
// Define CROSSHAIR_EN to overlay a 1-pixel crosshair inside the sprite.
import vga_pkg::*;

module vga_sprite_gen #(
  parameter int   SIZE       = 32,
  parameter rgb_t SPRITE_RGB = 24'hFF0000,
  parameter rgb_t BG_RGB     = 24'h000080,
  parameter int   H_ACT      = H_ACTIVE,
  parameter int   H_FRONT    = H_FP,
  parameter int   H_SYN      = H_SYNC,
  parameter int   H_BACK     = H_BP,
  parameter int   V_ACT      = V_ACTIVE,
  parameter int   V_FRONT    = V_FP,
  parameter int   V_SYN      = V_SYNC,
  parameter int   V_BACK     = V_BP
) (
  input  logic clk,
  input  logic reset_n,
  input  pos_t centerX,
  input  pos_t centerY,
  output logic SOF,
  output logic EOF,
  vga_sprite_gen_if.master vga
);

  localparam scmp_t HALF = scmp_t'(SIZE / 2);
  localparam scmp_t ONE  = 13'sd1;

  cnt_t  hcnt, vcnt;
  logic  last, hsync, vsync, blank;
  pos_t  cx_q, cy_q;
  rgb_t  rgb_q, rgb_d;
  scmp_t hs, vs, cxs, cys;
  scmp_t xlo, xhi, ylo, yhi;
  logic  act, hit;

  vga_timing #(
    .H_ACT   (H_ACT),
    .H_FRONT (H_FRONT),
    .H_SYN   (H_SYN),
    .H_BACK  (H_BACK),
    .V_ACT   (V_ACT),
    .V_FRONT (V_FRONT),
    .V_SYN   (V_SYN),
    .V_BACK  (V_BACK)
  ) u_timing (
    .clk     (clk),
    .reset_n (reset_n),
    .hcnt_o  (hcnt),
    .vcnt_o  (vcnt),
    .last_o  (last),
    .hsync_o (hsync),
    .vsync_o (vsync),
    .blank_o (blank),
    .sof_o   (SOF),
    .eof_o   (EOF)
  );

  // Signed 13-bit compare so off-screen centres clip without wrap.
  always_comb begin
    hs  = {2'b00, hcnt};
    vs  = {2'b00, vcnt};
    cxs = {{2{cx_q[10]}}, cx_q};
    cys = {{2{cy_q[10]}}, cy_q};
    xlo = cxs - HALF;
    xhi = cxs + HALF - ONE;
    ylo = cys - HALF;
    yhi = cys + HALF - ONE;
    hit = (hs >= xlo) && (hs <= xhi) &&
          (vs >= ylo) && (vs <= yhi);
    act = in_win(hcnt, 0, H_ACT - 1) &&
          in_win(vcnt, 0, V_ACT - 1);
    rgb_d = '0;
    if (act) begin
      rgb_d = hit ? SPRITE_RGB : BG_RGB;
    end
`ifdef CROSSHAIR_EN
    if (act && hit && ((hs == cxs) || (vs == cys))) begin
      rgb_d = ~SPRITE_RGB;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cx_q  <= RESET_CX;
      cy_q  <= RESET_CY;
      rgb_q <= '0;
    end else begin
      rgb_q <= rgb_d;
      if (last) begin
        cx_q <= centerX;
        cy_q <= centerY;
      end
    end
  end

  assign vga.hsync = hsync;
  assign vga.vsync = vsync;
  assign vga.blank = blank;
  assign vga.r     = rgb_q[23:16];
  assign vga.g     = rgb_q[15:8];
  assign vga.b     = rgb_q[7:0];

endmodule
